// File: rtl/eau_pkg.sv
`default_nettype none
// =====================================================================
// Package  : eau_pkg
// Brief    : Shared lane-geometry helpers, controller state encoding and
//            the trimux beat record.
// Revision : 1.0
// =====================================================================
package eau_pkg;

    function automatic int calc_bs(input int bsw);
        return 1 << bsw;
    endfunction

    function automatic int calc_ww(input int bsw);
        return 8 - bsw + 1;
    endfunction

    localparam int C_BSW = 5;
    localparam int C_BS  = calc_bs(C_BSW);
    localparam int C_WW  = calc_ww(C_BSW);

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_SCAN = 2'd1;
    localparam logic [1:0] C_ST_EMIT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = C_ST_IDLE,
        ST_SCAN = C_ST_SCAN,
        ST_EMIT = C_ST_EMIT
    } trimux_ctrl_state_e;

    typedef struct packed {
        logic [C_BSW:0]                 num;
        logic [C_BS-1:0][C_WW-1:0]      len;
        logic [C_BS-1:0][C_BSW-1:0]     pos;
        logic [C_BS-1:0][C_BSW-1:0]     psum;
        logic                           last;
    } trimux_beat_t;

endpackage
`default_nettype wire

// File: rtl/trimux_ctrl_stats.sv
`default_nettype none
// =====================================================================
// Module   : trimux_ctrl_stats
// Brief    : Wrapping 32-bit beat and vector handshake counters.
// Revision : 1.0
// =====================================================================
module trimux_ctrl_stats (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vec_fire,
    input  logic        beat_fire,
    output logic [31:0] stat_beats,
    output logic [31:0] stat_vecs
);

    logic [31:0] r_beats;
    logic [31:0] r_vecs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beats <= '0;
            r_vecs  <= '0;
        end else begin
            if (beat_fire) r_beats <= r_beats + 32'd1;
            if (vec_fire)  r_vecs  <= r_vecs + 32'd1;
        end
    end

    assign stat_beats = r_beats;
    assign stat_vecs  = r_vecs;

endmodule
`default_nettype wire

// File: rtl/trimux_ctrl.sv
`default_nettype none
// =====================================================================
// Module   : trimux_ctrl
// Brief    : Splits a descriptor vector into prefix-summed beats for trimux.
//            Counters are built only when TRIMUX_CTRL_STATS_EN is defined.
// Revision : 1.0
// =====================================================================
module trimux_ctrl
    import eau_pkg::*;
#(
    parameter  int VLEN = 256,
    parameter  int BSW  = C_BSW,
    localparam int BS   = calc_bs(BSW),
    localparam int WW   = calc_ww(BSW)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [BSW:0]   in_num,
    input  logic [WW-1:0]  in_len [BS],
    input  logic [BSW-1:0] in_pos [BS],
    output logic           out_valid,
    input  logic           out_ready,
    output logic [BSW:0]   out_num,
    output logic [WW-1:0]  out_len [BS],
    output logic [BSW-1:0] out_pos [BS],
    output logic [BSW-1:0] out_psum [BS],
    output logic           out_last,
    output logic [31:0]    stat_beats,
    output logic [31:0]    stat_vecs
);

    // Wide enough that sum + len never wraps before the fit compare.
    localparam int                  C_SUMW    = ((BSW + 1 > WW) ? BSW + 1 : WW) + 1;
    localparam logic [C_SUMW-1:0]   C_SUM_MAX = C_SUMW'(BS - 1);
    localparam logic [BSW:0]        C_ONE     = 1;

    // The beat record is sized for the package lane geometry.
    if ((BSW != C_BSW) || ((VLEN % BS) != 0)) begin : g_cfg_chk
        $error("trimux_ctrl: unsupported lane configuration");
    end

    trimux_ctrl_state_e  r_state;
    trimux_ctrl_state_e  w_state_nxt;

    logic [BSW:0]        r_num;
    logic [WW-1:0]       r_len [BS];
    logic [BSW-1:0]      r_pos [BS];
    logic [BSW:0]        r_cnt;
    logic [BSW:0]        r_k;
    logic [C_SUMW-1:0]   r_sum;
    trimux_beat_t        r_beat;

    logic [BSW-1:0]      w_eidx;
    logic [BSW-1:0]      w_kidx;
    logic [WW-1:0]       w_elen;
    logic [C_SUMW-1:0]   w_new_sum;
    logic                w_fit;
    logic                w_final;

    assign w_eidx    = r_cnt[BSW-1:0];
    assign w_kidx    = r_k[BSW-1:0];
    assign w_elen    = r_len[w_eidx];
    assign w_new_sum = r_sum + C_SUMW'(w_elen);
    assign w_fit     = (w_new_sum <= C_SUM_MAX);
    assign w_final   = ((r_cnt + C_ONE) == r_num);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid && (in_num != '0)) w_state_nxt = ST_SCAN;
            ST_SCAN: if (!w_fit || w_final)          w_state_nxt = ST_EMIT;
            ST_EMIT: if (out_ready)                  w_state_nxt = r_beat.last ? ST_IDLE : ST_SCAN;
            default:                                 w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: in_ready  = 1'b1;
            ST_EMIT: out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num  <= '0;
            r_cnt  <= '0;
            r_k    <= '0;
            r_sum  <= '0;
            r_beat <= '0;
            for (int i = 0; i < BS; i++) begin
                r_len[i] <= '0;
                r_pos[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_num <= in_num;
                        r_cnt <= '0;
                        r_k   <= '0;
                        r_sum <= '0;
                        for (int i = 0; i < BS; i++) begin
                            r_len[i] <= in_len[i];
                            r_pos[i] <= in_pos[i];
                        end
                    end
                end
                ST_SCAN: begin
                    if (w_fit) begin
                        r_beat.len[w_kidx]  <= w_elen;
                        r_beat.pos[w_kidx]  <= r_pos[w_eidx];
                        r_beat.psum[w_kidx] <= w_new_sum[BSW-1:0];
                        r_beat.num          <= r_k + C_ONE;
                        r_beat.last         <= w_final;
                        r_k                 <= r_k + C_ONE;
                        r_cnt               <= r_cnt + C_ONE;
                        r_sum               <= w_new_sum;
                    end else begin
                        // Rejected element stays at r_cnt and opens the next beat.
                        r_beat.num  <= r_k;
                        r_beat.last <= 1'b0;
                    end
                end
                ST_EMIT: begin
                    if (out_ready && !r_beat.last) begin
                        r_k   <= '0;
                        r_sum <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_num  = r_beat.num;
    assign out_last = r_beat.last;

    for (genvar i = 0; i < BS; i++) begin : g_slot
        assign out_len[i]  = r_beat.len[i];
        assign out_pos[i]  = r_beat.pos[i];
        assign out_psum[i] = r_beat.psum[i];
    end

`ifdef TRIMUX_CTRL_STATS_EN
    trimux_ctrl_stats u_stats (
        .clk        (clk),
        .rst_n      (rst_n),
        .vec_fire   (in_valid && in_ready),
        .beat_fire  (out_valid && out_ready),
        .stat_beats (stat_beats),
        .stat_vecs  (stat_vecs)
    );
`else
    assign stat_beats = '0;
    assign stat_vecs  = '0;
`endif

endmodule
`default_nettype wire
